// File: rtl/period_meter.sv
// Period meter: measures the spacing of sig_in rising edges in clk_in cycles,
// flags lock when consecutive periods agree within TOL, and raises a sticky
// timeout when sig_in stops toggling.
module period_meter #(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter int unsigned TOL     = 2,
  parameter int unsigned LOCK_N  = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_VAL  = CNT_W'(TOL);
  localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_N);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] period_d;
  logic             valid_d, locked_d, timeout_d;
  logic [MW-1:0]    match, match_d;
  logic             have_prev, have_prev_d;
  logic [CNT_W-1:0] diff;
  logic             s1, s2, s3;
  logic             rise;

  // Two-flop synchronizer plus history flop for rising-edge detection
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Unsigned distance between the running count and the last period
  assign diff = (cnt >= period) ? (cnt - period) : (period - cnt);

  // Next-state and output computation
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    period_d    = period;
    valid_d     = 1'b0;
    locked_d    = locked;
    timeout_d   = timeout;
    match_d     = match;
    have_prev_d = have_prev;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d     = MEASURE;
          cnt_d       = CNT_W'(1);
          have_prev_d = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          // Rise takes priority over an expiring count on the same edge
          period_d    = cnt;
          valid_d     = 1'b1;
          cnt_d       = CNT_W'(1);
          timeout_d   = 1'b0;
          have_prev_d = 1'b1;
          if (!have_prev) begin
            match_d = '0;
          end else if (diff <= TOL_VAL) begin
            match_d = (match == LOCK_VAL) ? match : match + MW'(1);
          end else begin
            match_d = '0;
          end
          locked_d = (match_d == LOCK_VAL);
        end else if (cnt == TO_VAL) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      match        <= '0;
      have_prev    <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      period       <= period_d;
      period_valid <= valid_d;
      locked       <= locked_d;
      timeout      <= timeout_d;
      match        <= match_d;
      have_prev    <= have_prev_d;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus predicts measurements from the
// times at which it raises sig_in; a monitor compares DUT outputs as they appear.
module tb_period_meter;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned TO     = 3000;
  localparam int unsigned TOL    = 2;
  localparam int unsigned LOCK_N = 4;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid, locked, timeout;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in),
    .period(period), .period_valid(period_valid), .locked(locked), .timeout(timeout)
  );

  always #50 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct packed { logic [31:0] per; logic lck; } exp_t;
  exp_t        exp_q[$];
  int unsigned to_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state: rise times in clock edges
  bit          m_meas = 0, m_prev_ok = 0;
  int unsigned m_last = 0, m_prev = 0, m_match = 0;

  function automatic int unsigned absdiff(int unsigned a, int unsigned b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic void model_rise(int unsigned r);
    int unsigned p;
    if (m_meas && (r - m_last > TO)) begin
      to_q.push_back(m_last + TO);
      m_meas = 0; m_match = 0;
    end
    if (!m_meas) begin
      m_meas = 1; m_prev_ok = 0; m_last = r;
    end else begin
      p = r - m_last;
      m_last = r;
      if (!m_prev_ok) m_match = 0;
      else if (absdiff(p, m_prev) <= TOL) m_match = (m_match < LOCK_N) ? m_match + 1 : LOCK_N;
      else m_match = 0;
      m_prev = p; m_prev_ok = 1;
      exp_q.push_back('{per: p, lck: (m_match == LOCK_N)});
    end
  endfunction

  function automatic void model_quiet_until(int unsigned e);
    if (m_meas && (m_last + TO <= e)) begin
      to_q.push_back(m_last + TO);
      m_meas = 0; m_match = 0;
    end
  endfunction

  function automatic void model_reset();
    m_meas = 0; m_prev_ok = 0; m_match = 0;
  endfunction

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at cyc %0d", name, got, want, cyc);
    end
  endtask

  // Rising edge at this negedge; sig_in high for hi cycles, low for lo cycles
  task automatic pulse(input int unsigned hi, input int unsigned lo, input bit glitch = 0);
    @(negedge clk_in);
    sig_in = 1'b1;
    model_rise(cyc + 3);
    repeat (hi) @(negedge clk_in);
    sig_in = 1'b0;
    if (glitch) begin
      @(negedge clk_in);
      #10 sig_in = 1'b1;
      #20 sig_in = 1'b0;
      repeat (lo - 2) @(negedge clk_in);
    end else begin
      repeat (lo - 1) @(negedge clk_in);
    end
  endtask

  task automatic quiet(input int unsigned n);
    sig_in = 1'b0;
    model_quiet_until(cyc + n + 2);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset(input bit sig_hi, input int unsigned n);
    @(negedge clk_in);
    rst = 1'b1;
    sig_in = sig_hi;
    model_reset();
    repeat (n) @(negedge clk_in);
    check("rst_period", period, 0);
    check("rst_valid", period_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    if (sig_hi) model_rise(cyc + 3);
  endtask

  // Monitor: compare each period_valid and each timeout assertion
  bit prev_to = 0;
  always @(negedge clk_in) begin
    exp_t        e;
    int unsigned t;
    if (period_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid got period=%0d expected no pulse at cyc %0d", period, cyc);
      end else begin
        e = exp_q.pop_front();
        check("period", period, e.per);
        check("locked", locked, e.lck);
        check("timeout_clear", timeout, 0);
      end
    end
    if (timeout && !prev_to) begin
      if (to_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_timeout got=1 expected=0 at cyc %0d", cyc);
      end else begin
        t = to_q.pop_front();
        check("timeout_cycle", cyc, t);
        check("locked_at_timeout", locked, 0);
      end
    end
    prev_to = timeout;
  end

  initial begin
    int unsigned base, p, hi;
    do_reset(0, 5);
    quiet(20);
    repeat (7) pulse(100, 100);
    pulse(100, 103);
    repeat (6) pulse(100, 103);
    repeat (8) begin
      pulse(100, 100);
      pulse(100, 102);
    end
    quiet(TO + 100);
    repeat (4) pulse(60, 60, 1);
    pulse(50, 700);
    do_reset(0, 4);
    quiet(30);
    repeat (5) pulse(100, 150);
    do_reset(1, 4);
    repeat (50) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (150) @(negedge clk_in);
    repeat (4) pulse(80, 80);
    repeat (7) pulse(2, 48, 1);
    base = 100;
    for (int i = 0; i < 30; i++) begin
      if (i % 10 == 0) base = $urandom_range(40, 400);
      p  = base + $urandom_range(0, 3);
      hi = $urandom_range(2, p - 3);
      pulse(hi, p - hi, ($urandom_range(0, 3) == 0));
    end
    pulse(100, TO - 100);
    pulse(100, TO + 1 - 100);
    repeat (3) pulse(100, 100);
    quiet(20);
    check("exp_q_drained", exp_q.size(), 0);
    check("to_q_drained", to_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(100_000 * 100);
    bad++;
    $display("FAIL watchdog got=running expected=finished at cyc %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
